// File: rtl/parking_gate_sequencer.sv
// parking_gate_sequencer: round-robin sequencing of one barrier gate across four lanes
// with request latching, open/pass/close phases and free-space counters for both pools.
module parking_gate_sequencer #(
  parameter int N_CAP     = 20,
  parameter int H_CAP     = 5,
  parameter int OPEN_CYC  = 4,
  parameter int CLOSE_CYC = 4,
  parameter int PASS_TMO  = 16,
  parameter int TMR_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_n_in,
  input  logic       req_n_out,
  input  logic       req_h_in,
  input  logic       req_h_out,
  input  logic       pass_beam,
  output logic [4:0] n_free,
  output logic [2:0] h_free,
  output logic       n_full,
  output logic       h_full,
  output logic       gate_open,
  output logic       gate_close,
  output logic       busy,
  output logic [1:0] grant_id,
  output logic       served,
  output logic       reject,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, OPENING, WAIT_PASS, CLOSING} state_t;
  localparam logic [4:0] N_CAP5 = 5'(N_CAP);
  localparam logic [2:0] H_CAP3 = 3'(H_CAP);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(PASS_TMO - 1);
  state_t           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [3:0]       pending_q, pending_d, req, elig, gnt_oh;
  logic [1:0]       rr_ptr_q, grant_id_q, gnt;
  logic [4:0]       n_free_q, n_free_d;
  logic [2:0]       h_free_q, h_free_d;
  logic             found, pass_ev;
  logic             gate_open_q, gate_close_q, served_q, reject_q, timeout_q;
  always_comb begin
    req = {req_h_out, req_h_in, req_n_out, req_n_in};
    elig = {h_free_q != H_CAP3, h_free_q != '0, n_free_q != N_CAP5, n_free_q != '0};
    gnt = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && pending_q[rr_ptr_q + 2'(k)]) begin
        found = 1'b1;
        gnt = rr_ptr_q + 2'(k);
      end
    end
    gnt_oh = (state_q == IDLE && found) ? 4'b0001 << gnt : 4'b0000;
    // a fresh pulse on the lane being granted keeps its pending bit set
    pending_d = (pending_q & ~gnt_oh) | (req & elig);
    pass_ev = (state_q == WAIT_PASS) && pass_beam;
    n_free_d = !pass_ev ? n_free_q :
               (grant_id_q == 2'd0 && n_free_q != '0)     ? n_free_q - 5'd1 :
               (grant_id_q == 2'd1 && n_free_q != N_CAP5) ? n_free_q + 5'd1 : n_free_q;
    h_free_d = !pass_ev ? h_free_q :
               (grant_id_q == 2'd2 && h_free_q != '0)     ? h_free_q - 3'd1 :
               (grant_id_q == 2'd3 && h_free_q != H_CAP3) ? h_free_q + 3'd1 : h_free_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      n_free_q     <= N_CAP5;
      h_free_q     <= H_CAP3;
      gate_open_q  <= 1'b0;
      gate_close_q <= 1'b0;
      served_q     <= 1'b0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      n_free_q  <= n_free_d;
      h_free_q  <= h_free_d;
      reject_q  <= |(req & ~elig);
      served_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (found) begin
          state_q     <= OPENING;
          grant_id_q  <= gnt;
          rr_ptr_q    <= gnt + 2'd1;
          timer_q     <= '0;
          gate_open_q <= 1'b1;
        end
        OPENING: if (timer_q == OPEN_LAST) begin
          state_q     <= WAIT_PASS;
          timer_q     <= '0;
          gate_open_q <= 1'b0;
        end else timer_q <= timer_q + 1'b1;
        WAIT_PASS: if (pass_beam || timer_q == TMO_LAST) begin
          state_q      <= CLOSING;
          timer_q      <= '0;
          gate_close_q <= 1'b1;
          served_q     <= pass_beam;
          timeout_q    <= !pass_beam;
        end else timer_q <= timer_q + 1'b1;
        CLOSING: if (timer_q == CLOSE_LAST) begin
          state_q      <= IDLE;
          timer_q      <= '0;
          gate_close_q <= 1'b0;
        end else timer_q <= timer_q + 1'b1;
      endcase
    end
  end
  assign n_free     = n_free_q;
  assign h_free     = h_free_q;
  assign n_full     = n_free_q == '0;
  assign h_full     = h_free_q == '0;
  assign gate_open  = gate_open_q;
  assign gate_close = gate_close_q;
  assign busy       = state_q != IDLE;
  assign grant_id   = grant_id_q;
  assign served     = served_q;
  assign reject     = reject_q;
  assign timeout    = timeout_q;
endmodule

// File: tb/tb_parking_gate_sequencer.sv
// tb_parking_gate_sequencer: directed checks of arbitration, gate phases, counters,
// eligibility rejects, pass timeout and asynchronous reset.
module tb_parking_gate_sequencer;
  logic       clk = 1'b0, reset = 1'b1;
  logic       req_n_in = 1'b0, req_n_out = 1'b0, req_h_in = 1'b0, req_h_out = 1'b0;
  logic       pass_beam = 1'b0;
  logic [4:0] n_free;
  logic [2:0] h_free;
  logic       n_full, h_full, gate_open, gate_close, busy, served, reject, timeout;
  logic [1:0] grant_id;
  int n_chk = 0, n_fail = 0;
  parking_gate_sequencer dut (
    .clk(clk), .reset(reset), .req_n_in(req_n_in), .req_n_out(req_n_out),
    .req_h_in(req_h_in), .req_h_out(req_h_out), .pass_beam(pass_beam),
    .n_free(n_free), .h_free(h_free), .n_full(n_full), .h_full(h_full),
    .gate_open(gate_open), .gate_close(gate_close), .busy(busy), .grant_id(grant_id),
    .served(served), .reject(reject), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset;
    {req_h_out, req_h_in, req_n_out, req_n_in} = 4'b0000;
    pass_beam = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask
  task automatic pulse(input logic [3:0] r);
    {req_h_out, req_h_in, req_n_out, req_n_in} = r;
    tick(1);
    {req_h_out, req_h_in, req_n_out, req_n_in} = 4'b0000;
  endtask
  // Starts just after the edge entering OPENING, ends just after the edge back to IDLE.
  task automatic service(input int lane, input bit beam, input int n_exp, input int h_exp,
                         input bit dup);
    chk("grant_id", 32'(grant_id), lane);
    chk("open_busy", 32'(busy), 1);
    chk("open_first", 32'(gate_open), 1);
    chk("open_noclose", 32'(gate_close), 0);
    if (dup) begin
      req_n_in = 1'b1;
      tick(1);
      tick(1);
      req_n_in = 1'b0;
      chk("dup_noreject", 32'(reject), 0);
      tick(1);
    end else tick(3);
    chk("open_last", 32'(gate_open), 1);
    tick(1);
    chk("wait_open", 32'(gate_open), 0);
    chk("wait_close", 32'(gate_close), 0);
    chk("wait_busy", 32'(busy), 1);
    if (beam) begin
      pass_beam = 1'b1;
      tick(1);
      pass_beam = 1'b0;
      chk("served", 32'(served), 1);
      chk("no_timeout", 32'(timeout), 0);
    end else begin
      tick(16);
      chk("timeout", 32'(timeout), 1);
      chk("no_served", 32'(served), 0);
    end
    chk("close_first", 32'(gate_close), 1);
    chk("n_free", 32'(n_free), n_exp);
    chk("h_free", 32'(h_free), h_exp);
    tick(1);
    chk("served_pulse", 32'(served), 0);
    chk("timeout_pulse", 32'(timeout), 0);
    tick(3);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_close", 32'(gate_close), 0);
  endtask
  initial begin
    do_reset;
    chk("rst_n_free", 32'(n_free), 20);
    chk("rst_h_free", 32'(h_free), 5);
    chk("rst_n_full", 32'(n_full), 0);
    chk("rst_h_full", 32'(h_full), 0);
    chk("rst_open", 32'(gate_open), 0);
    chk("rst_close", 32'(gate_close), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_pulses", {29'd0, served, reject, timeout}, 0);
    // single normal entry: OPENING two edges after the pulse
    pulse(4'b0001);
    chk("t1_latched_busy", 32'(busy), 0);
    chk("t1_noreject", 32'(reject), 0);
    tick(1);
    service(0, 1'b1, 19, 5, 1'b0);
    tick(1);
    chk("t1_stay_idle", 32'(busy), 0);
    // all four at once from reset: n_out and h_out ineligible, one reject pulse
    do_reset;
    pulse(4'b1111);
    chk("t2_reject", 32'(reject), 1);
    chk("t2_busy", 32'(busy), 0);
    tick(1);
    chk("t2_reject_once", 32'(reject), 0);
    service(0, 1'b1, 19, 5, 1'b0);
    tick(1);
    service(2, 1'b1, 19, 4, 1'b0);
    tick(1);
    chk("t2_no_more", 32'(busy), 0);
    // rr_ptr now 3: order 3, 0, 2
    pulse(4'b1101);
    chk("t2b_noreject", 32'(reject), 0);
    tick(1);
    service(3, 1'b1, 19, 5, 1'b0);
    tick(1);
    service(0, 1'b1, 18, 5, 1'b0);
    tick(1);
    service(2, 1'b1, 18, 4, 1'b0);
    tick(1);
    chk("t2b_idle", 32'(busy), 0);
    // fill handicapped pool
    do_reset;
    for (int i = 0; i < 5; i++) begin
      pulse(4'b0100);
      tick(1);
      service(2, 1'b1, 20, 4 - i, 1'b0);
    end
    chk("t3_h_free0", 32'(h_free), 0);
    chk("t3_h_full", 32'(h_full), 1);
    pulse(4'b0100);
    chk("t3_reject", 32'(reject), 1);
    chk("t3_busy", 32'(busy), 0);
    tick(1);
    chk("t3_reject_end", 32'(reject), 0);
    chk("t3_still_idle", 32'(busy), 0);
    // pass timeout on lane 0
    pulse(4'b0001);
    tick(1);
    service(0, 1'b0, 20, 0, 1'b0);
    // re-request during OPENING, plus a duplicate absorbed
    pulse(4'b0001);
    tick(1);
    service(0, 1'b1, 19, 0, 1'b1);
    tick(1);
    service(0, 1'b1, 18, 0, 1'b0);
    tick(1);
    chk("t5_no_third", 32'(busy), 0);
    // asynchronous reset in WAIT_PASS with pending=1010
    do_reset;
    pulse(4'b0001);
    tick(1);
    service(0, 1'b1, 19, 5, 1'b0);
    pulse(4'b0100);
    tick(1);
    service(2, 1'b1, 19, 4, 1'b0);
    pulse(4'b0001);
    tick(1);
    chk("t6_open", 32'(gate_open), 1);
    pulse(4'b1010);
    chk("t6_noreject", 32'(reject), 0);
    tick(3);
    chk("t6_wait_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_open_off", 32'(gate_open), 0);
    chk("t6_close_off", 32'(gate_close), 0);
    chk("t6_idle", 32'(busy), 0);
    chk("t6_n_free", 32'(n_free), 20);
    chk("t6_h_free", 32'(h_free), 5);
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("t6_pending_dropped", 32'(busy), 0);
    chk("t6_gate_quiet", {30'd0, gate_open, gate_close}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
